uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel receive stage of the on-chip UART, directly upstream of the 32-entry receive FIFO in the MMIO block. It samples the asynchronous `serial_in` line, recovers 8N1 frames (1 start bit, 8 data bits LSB-first, 1 stop bit) and holds each byte in a one-entry output register. Bytes are offered through a valid/ready handshake whose ready input is the FIFO's not-full. It also flags framing errors and overruns for status reporting.

## Interface

**Parameters**
- `CLOCK_FREQ`, 50_000_000: clk frequency in Hz.
- `BAUD_RATE`, 115200: line rate in bit/s.
- Derived, not overridable:
  - `SYMBOL_EDGE_TIME` = CLOCK_FREQ/BAUD_RATE, in cycles per bit.
  - `SAMPLE_TIME` = SYMBOL_EDGE_TIME/2.
  - Counter width = $clog2(SYMBOL_EDGE_TIME).

**Ports**
- `clk`, input, 1: the single clock; all state is on its rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `serial_in`, input, 1: asynchronous RX line; idles high.
- `data_out`, output, 8: received byte.
- `data_out_valid`, output, 1: `data_out` holds an unconsumed byte.
- `data_out_ready`, input, 1: consumer accepts the byte (the FIFO's not-full).
- `framing_error`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `overrun`, output, 1: one-cycle pulse when a completed byte is dropped because the holding register is still full.

## Operation

- **Synchronizer.** `serial_in` passes through 2 flops, both reset to 1, giving `rx_s`. A third flop holds the previous value, `rx_q`. A start edge is `rx_q==1 && rx_s==0`.
- **State machine** (IDLE, START, DATA, STOP; resets to IDLE):
  - **IDLE:** on a start edge, clear the bit counter and go to START. A line held low (break) never retriggers.
  - **START:** at count SAMPLE_TIME-1, sample `rx_s`. If it is 1 (glitch), return to IDLE. Otherwise clear the counter and go to DATA.
  - **DATA:** every SYMBOL_EDGE_TIME cycles, shift `rx_s` into shift-register bit 7 (shifting right). After the 8th sample, go to STOP.
  - **STOP:** after SYMBOL_EDGE_TIME cycles, sample `rx_s` and act as below, then return to IDLE.
    - If it is 1 and the holding register is free, load it and set `data_out_valid`.
    - If it is 1 and the holding register is full, pulse `overrun` and discard the new byte; the old byte is retained.
    - If it is 0, pulse `framing_error` and discard the byte.
- **Holding register.** `data_out_valid` clears on a cycle with `valid && ready`.
  - "Free" means `!data_out_valid || data_out_ready` in the cycle of the stop sample.
  - A simultaneous handshake and load keeps `valid` at 1 with the new byte, and no overrun is flagged.
- `data_out` is stable while `valid` is high and ready is low.

## Timing

- **Reset values:**
  - `data_out` = 8'h00.
  - `data_out_valid` = 0.
  - `framing_error` = 0 and `overrun` = 0.
  - Synchronizer and `rx_q` = 1.
  - State = IDLE, counter = 0, shift register = 0.
- **Reset mid-frame** aborts the frame immediately: no partial byte, no error pulse.
- **Sample points**, relative to the cycle the start edge is detected:
  - Start bit at +SAMPLE_TIME.
  - Data bit k at +SAMPLE_TIME + (k+1)·SYMBOL_EDGE_TIME.
  - Stop bit at +SAMPLE_TIME + 9·SYMBOL_EDGE_TIME.
- **Output latency:** `data_out_valid` rises (or `framing_error`/`overrun` pulses) on the clk edge that takes the stop sample. The total latency from the `serial_in` fall to `valid` is 3 + SAMPLE_TIME + 9·SYMBOL_EDGE_TIME cycles.
- **Back-to-back frames:** after the stop sample, the FSM is in IDLE the next cycle. A start edge arriving half a bit later is caught.
- **Counter:** counts 0..SYMBOL_EDGE_TIME-1 and wraps. It never overflows its width.

## Structure

- Shared package `uart_pkg` holds:
  - The state encoding (`UART_RX_IDLE`/`START`/`DATA`/`STOP`).
  - The SYMBOL_EDGE_TIME/SAMPLE_TIME derivation, which is also used by the transmitter.
- One sub-module, `sync_2ff`: a 1-bit synchronizer with a reset-value parameter (set to 1 here).
- FSM, counters, shift register and holding register live in `uart_receiver`.

## Test plan

All scenarios use CLOCK_FREQ=1000 and BAUD_RATE=100, so SYMBOL_EDGE_TIME=10 and SAMPLE_TIME=5.

- **Single byte.** Send 8'hA5 and hold ready=1. Expected: `valid` rises at cycle 3+5+90=98 after the fall, `data_out`=8'hA5, and `valid` drops the next cycle.
- **Back-pressure and overrun.** Hold ready=0 and send 8'h3C then 8'hC3.
  - Expected: `data_out` stays 8'h3C, and `overrun` pulses once at the second stop sample.
  - Then raise ready. Expected: `valid` falls, with no second byte.
- **Framing error.** Send 8'h55 with the stop bit low. Expected:
  - One `framing_error` pulse and `valid` stays 0.
  - The line then stays low for 30 cycles; expect no new frame.
  - It returns high and 8'h12 is sent; expect 8'h12 to be received.
- **Glitch rejection.** Drive `serial_in` low for 3 cycles, then high. Expected: no `valid`, no error pulse, FSM back in IDLE.
- **Simultaneous handshake.** Leave 8'h01 pending with ready=0, and raise ready exactly on the stop-sample cycle of 8'h02. Expected: `valid` stays 1, `data_out`=8'h02, no overrun.
- **Reset mid-frame.** Assert reset during data bit 4 of 8'hFF. Expected:
  - Outputs return to their reset values.
  - After release, 8'h7E is sent and received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing derivation
// (the timing helpers are also used by the transmitter).
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    UART_RX_IDLE  = 2'd0,
    UART_RX_START = 2'd1,
    UART_RX_DATA  = 2'd2,
    UART_RX_STOP  = 2'd3
  } uart_rx_state_e;

  function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                   input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic int unsigned sample_time(input int unsigned clock_freq,
                                              input int unsigned baud_rate);
    return symbol_edge_time(clock_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receive-side output bundle: byte handshake toward the RX FIFO plus status pulses.
interface uart_receiver_if;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overrun;

  modport master (
    output data_out, data_out_valid, framing_error, overrun,
    input  data_out_ready
  );

  modport slave (
    input  data_out, data_out_valid, framing_error, overrun,
    output data_out_ready
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: start-edge detect, mid-bit sampling, one-entry
// holding register with valid/ready handshake, framing-error and overrun pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200
) (
  input  logic clk,
  input  logic reset,
  input  logic serial_in,
  uart_receiver_if.master rx
);
  localparam int unsigned SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned SAMPLE_TIME      = sample_time(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);

  logic rx_s;
  logic rx_q;

  uart_rx_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             fe_q, fe_d;
  logic             ov_q, ov_d;

  sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (serial_in),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_q    <= 1'b1;
      state_q <= UART_RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      rx_q    <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign cnt_inc = (cnt_q == SYMBOL_LAST) ? '0 : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q && !rx.data_out_ready;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    unique case (state_q)
      UART_RX_IDLE: begin
        // Edge, not level: a held-low break line cannot retrigger a frame.
        if (rx_q && !rx_s) begin
          cnt_d   = '0;
          state_d = UART_RX_START;
        end
      end
      UART_RX_START: begin
        cnt_d = cnt_inc;
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? UART_RX_IDLE : UART_RX_DATA;
        end
      end
      UART_RX_DATA: begin
        cnt_d = cnt_inc;
        if (cnt_q == SYMBOL_LAST) begin
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = UART_RX_STOP;
        end
      end
      UART_RX_STOP: begin
        cnt_d = cnt_inc;
        if (cnt_q == SYMBOL_LAST) begin
          state_d = UART_RX_IDLE;
          // A handshake in the stop-sample cycle frees the register for the new byte.
          if (!rx_s) begin
            fe_d = 1'b1;
          end else if (!valid_q || rx.data_out_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ov_d = 1'b1;
          end
        end
      end
      default: state_d = UART_RX_IDLE;
    endcase
  end

  assign rx.data_out       = data_q;
  assign rx.data_out_valid = valid_q;
  assign rx.framing_error  = fe_q;
  assign rx.overrun        = ov_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at 10 cycles/bit: directed frames push
// expected bytes/status pulses, a negedge monitor pops and compares them.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned BAUD    = 100;
  localparam int unsigned BIT_CYC = 10;
  localparam int unsigned LATENCY = 98;

  typedef enum int {EV_FE, EV_OV} ev_e;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic serial_in = 1'b1;
  int unsigned cyc = 0;
  int unsigned fall_cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [7:0] exp_data[$];
  ev_e        exp_evt[$];

  uart_receiver_if rx_if();

  uart_receiver #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
    .clk       (clk),
    .reset     (reset),
    .serial_in (serial_in),
    .rx        (rx_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_evt(input ev_e ev, input string name);
    ev_e e;
    if (exp_evt.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got pulse, required none (t=%0t)", name, $time);
    end else begin
      e = exp_evt.pop_front();
      check({"event_", name}, 32'(ev), 32'(e));
    end
  endtask

  // Monitor: every pulse and every accepted byte must match the next expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_if.framing_error) pop_evt(EV_FE, "framing_error");
      if (rx_if.overrun) pop_evt(EV_OV, "overrun");
      if (rx_if.data_out_valid && rx_if.data_out_ready) begin
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h, required none (t=%0t)", rx_if.data_out, $time);
        end else begin
          check("rx_byte", 32'(rx_if.data_out), 32'(exp_data.pop_front()));
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge clk); #1;
    fall_cyc  = cyc;
    serial_in = 1'b0;
    repeat (BIT_CYC) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (BIT_CYC) @(posedge clk);
      #1;
    end
    serial_in = stop;
    repeat (BIT_CYC) @(posedge clk);
    #1;
  endtask

  task automatic wait_rel(input int unsigned rel);
    @(posedge clk); #2;
    while (cyc != fall_cyc + rel) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_data.size() != 0 || exp_evt.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_bytes_left"}, 32'(exp_data.size()), 32'd0);
    check({name, "_events_left"}, 32'(exp_evt.size()), 32'd0);
  endtask

  initial begin
    rx_if.data_out_ready = 1'b1;
    @(negedge clk);
    check("reset_data", 32'(rx_if.data_out), 32'h00);
    check("reset_valid", 32'(rx_if.data_out_valid), 32'd0);
    check("reset_fe", 32'(rx_if.framing_error), 32'd0);
    check("reset_ov", 32'(rx_if.overrun), 32'd0);
    check("reset_state", 32'(dut.state_q), 32'(UART_RX_IDLE));
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);

    // Single byte with exact latency
    exp_data.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        int n = 0;
        @(negedge clk);
        while (!rx_if.data_out_valid && n < 300) begin
          @(negedge clk);
          n++;
        end
        check("single_valid", 32'(rx_if.data_out_valid), 32'd1);
        check("single_latency", cyc - fall_cyc, LATENCY);
        @(negedge clk);
        check("single_valid_drop", 32'(rx_if.data_out_valid), 32'd0);
      end
    join
    drain("single");

    // Back-pressure and overrun
    rx_if.data_out_ready = 1'b0;
    exp_evt.push_back(EV_OV);
    exp_data.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    @(negedge clk);
    check("bp_data_held", 32'(rx_if.data_out), 32'h3C);
    check("bp_valid_held", 32'(rx_if.data_out_valid), 32'd1);
    @(posedge clk); #1 rx_if.data_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid_fall", 32'(rx_if.data_out_valid), 32'd0);
    drain("backpressure");

    // Framing error, break, then recovery
    exp_evt.push_back(EV_FE);
    send_frame(8'h55, 1'b0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("break_no_valid", 32'(rx_if.data_out_valid), 32'd0);
    check("break_idle", 32'(dut.state_q), 32'(UART_RX_IDLE));
    @(posedge clk); #1 serial_in = 1'b1;
    repeat (20) @(posedge clk);
    exp_data.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    drain("framing");

    // Glitch rejection
    @(posedge clk); #1 serial_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 serial_in = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("glitch_idle", 32'(dut.state_q), 32'(UART_RX_IDLE));
    check("glitch_no_valid", 32'(rx_if.data_out_valid), 32'd0);

    // Handshake in the same cycle as the stop sample
    rx_if.data_out_ready = 1'b0;
    exp_data.push_back(8'h01);
    exp_data.push_back(8'h02);
    send_frame(8'h01, 1'b1);
    fork
      send_frame(8'h02, 1'b1);
      begin
        wait_rel(LATENCY - 1);
        rx_if.data_out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("simul_valid", 32'(rx_if.data_out_valid), 32'd1);
        check("simul_data", 32'(rx_if.data_out), 32'h02);
      end
    join
    drain("simultaneous");

    // Reset during data bit 4
    fork
      send_frame(8'hFF, 1'b1);
      begin
        wait_rel(55);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_data", 32'(rx_if.data_out), 32'h00);
        check("midrst_valid", 32'(rx_if.data_out_valid), 32'd0);
        check("midrst_fe", 32'(rx_if.framing_error), 32'd0);
        check("midrst_ov", 32'(rx_if.overrun), 32'd0);
        check("midrst_state", 32'(dut.state_q), 32'(UART_RX_IDLE));
        @(posedge clk); #1 reset = 1'b0;
      end
    join
    repeat (20) @(posedge clk);
    exp_data.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    drain("after_reset");

    repeat (20) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
